// File: rtl/rd53_sync_fe_pkg.sv
// Shared types and default constants for the synchronous front-end pixel control logic.
package rd53_sync_fe_pkg;

    localparam int unsigned DEF_TOT_W      = 4;
    localparam int unsigned DEF_BCID_W     = 8;
    localparam int unsigned DEF_AZ_PERIOD  = 256;
    localparam int unsigned DEF_AZ_LEN     = 4;
    localparam int unsigned DEF_SETTLE_LEN = 2;
    localparam int unsigned DEF_OVF_W      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAz,
        StSettle,
        StArmed,
        StTot
    } fe_state_e;

    typedef struct packed {
        logic [DEF_TOT_W-1:0]  tot;
        logic [DEF_BCID_W-1:0] bcid;
    } hit_t;

endpackage

// File: rtl/rd53_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-high reset.
module rd53_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rd53_sync_fe_digital_ctrl.sv
// Pixel-side controller for the synchronous analog front end: autozero sequencing,
// time-over-threshold measurement and a single-entry hit output register.
module rd53_sync_fe_digital_ctrl
    import rd53_sync_fe_pkg::*;
#(
    parameter int unsigned TOT_W      = DEF_TOT_W,
    parameter int unsigned BCID_W     = DEF_BCID_W,
    parameter int unsigned AZ_PERIOD  = DEF_AZ_PERIOD,
    parameter int unsigned AZ_LEN     = DEF_AZ_LEN,
    parameter int unsigned SETTLE_LEN = DEF_SETTLE_LEN,
    parameter int unsigned OVF_W      = DEF_OVF_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_disc_in,
    input  logic [BCID_W-1:0] i_bcid,
    input  logic              i_az_force,
    output logic              o_phi_az_to,
    output logic              o_strobe_to,
    output logic              o_hit_valid,
    input  logic              i_hit_ready,
    output logic [TOT_W-1:0]  o_hit_tot,
    output logic [BCID_W-1:0] o_hit_bcid,
    output logic [OVF_W-1:0]  o_ovf_cnt
);

    localparam int unsigned PH_MAX = (AZ_LEN > SETTLE_LEN) ? AZ_LEN : SETTLE_LEN;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned TMR_W  = $clog2(AZ_PERIOD + 1);
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    typedef struct packed {
        logic [TOT_W-1:0]  tot;
        logic [BCID_W-1:0] bcid;
    } hit_rec_t;

    fe_state_e         r_state;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [TMR_W-1:0]  r_az_tmr;
    logic              r_az_pend;
    logic [TOT_W-1:0]  r_tot;
    logic [BCID_W-1:0] r_lead_bcid;
    logic              r_phi;
    logic              r_strobe;
    logic              r_ds_prev;
    hit_rec_t          r_hit;
    logic              r_hit_valid;
    logic [OVF_W-1:0]  r_ovf;

    logic w_ds;
    logic w_lead;
    logic w_expire;
    logic w_az_req;
    logic w_emit;

    rd53_sync_2ff #(
        .WIDTH (1)
    ) u_disc_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_disc_in),
        .o_q   (w_ds)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ds_prev <= 1'b0;
        end else begin
            r_ds_prev <= w_ds;
        end
    end

    assign w_lead   = w_ds & ~r_ds_prev;
    assign w_expire = (r_az_tmr == TMR_W'(AZ_PERIOD - 1));
    // Any of these pending, forced now, or timer expiry asks for an autozero.
    assign w_az_req = r_az_pend | i_az_force | w_expire;
    assign w_emit   = (r_state == StTot) && i_enable && !w_ds;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_ph_cnt    <= '0;
            r_az_tmr    <= '0;
            r_az_pend   <= 1'b0;
            r_tot       <= '0;
            r_lead_bcid <= '0;
            r_phi       <= 1'b0;
            r_strobe    <= 1'b0;
        end else if (!i_enable) begin
            r_state   <= StIdle;
            r_az_pend <= 1'b0;
            r_az_tmr  <= '0;
            r_phi     <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            if ((r_state == StArmed || r_state == StTot) && !w_expire) begin
                r_az_tmr <= r_az_tmr + 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    r_state  <= StAz;
                    r_ph_cnt <= '0;
                    r_phi    <= 1'b1;
                end
                StAz: begin
                    if (r_ph_cnt == PH_W'(AZ_LEN - 1)) begin
                        r_state  <= StSettle;
                        r_ph_cnt <= '0;
                        r_phi    <= 1'b0;
                        r_az_tmr <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                StSettle: begin
                    if (r_ph_cnt == PH_W'(SETTLE_LEN - 1)) begin
                        r_state  <= StArmed;
                        r_strobe <= 1'b1;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                StArmed: begin
                    // A leading edge beats an autozero request; the request is kept pending.
                    if (w_lead) begin
                        r_state     <= StTot;
                        r_tot       <= TOT_W'(1);
                        r_lead_bcid <= i_bcid;
                        r_az_pend   <= w_az_req;
                    end else if (w_az_req) begin
                        r_state   <= StAz;
                        r_ph_cnt  <= '0;
                        r_phi     <= 1'b1;
                        r_strobe  <= 1'b0;
                        r_az_pend <= 1'b0;
                    end
                end
                StTot: begin
                    if (w_ds) begin
                        if (r_tot != TOT_MAX) begin
                            r_tot <= r_tot + 1'b1;
                        end
                        r_az_pend <= w_az_req;
                    end else if (w_az_req) begin
                        r_state   <= StAz;
                        r_ph_cnt  <= '0;
                        r_phi     <= 1'b1;
                        r_strobe  <= 1'b0;
                        r_az_pend <= 1'b0;
                    end else begin
                        r_state <= StArmed;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit       <= '0;
            r_hit_valid <= 1'b0;
            r_ovf       <= '0;
        end else if (w_emit) begin
            // Accept in the same cycle frees the slot, so the new record loads without a bubble.
            if (!r_hit_valid || i_hit_ready) begin
                r_hit       <= '{tot: r_tot, bcid: r_lead_bcid};
                r_hit_valid <= 1'b1;
            end else if (r_ovf != OVF_MAX) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end else if (r_hit_valid && i_hit_ready) begin
            r_hit_valid <= 1'b0;
        end
    end

    assign o_phi_az_to = r_phi;
    assign o_strobe_to = r_strobe;
    assign o_hit_valid = r_hit_valid;
    assign o_hit_tot   = r_hit.tot;
    assign o_hit_bcid  = r_hit.bcid;
    assign o_ovf_cnt   = r_ovf;

endmodule

// File: tb/tb_rd53_sync_fe_digital_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a behavioural model of the front-end controller.
module tb_rd53_sync_fe_digital_ctrl;
    import rd53_sync_fe_pkg::*;

    localparam int unsigned AZ_P    = 16;
    localparam int unsigned AZ_L    = 4;
    localparam int unsigned SET_L   = 2;
    localparam int unsigned TOT_MAX = 15;
    localparam int unsigned OVF_MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       disc_in = 1'b0;
    logic       az_force = 1'b0;
    logic       hit_ready = 1'b0;
    logic [7:0] bcid = '0;
    logic       o_phi;
    logic       o_strobe;
    logic       o_valid;
    logic [3:0] o_tot;
    logic [7:0] o_bcid;
    logic [7:0] o_ovf;

    int errors = 0;
    int checks = 0;
    int bc_ctr = 0;

    // Behavioural model: remaining-cycle counters per phase instead of a state code.
    bit m_s1, m_ds, m_dsp;
    int m_az_left, m_set_left, m_since, m_tot, m_hb;
    bit m_live, m_pulse, m_pend;
    bit m_vld;
    int m_otot, m_obc, m_ovf;

    typedef struct {
        int   rep;
        bit   en;
        bit   disc;
        bit   rdy;
        bit   phi;
        bit   strb;
        bit   vld;
        hit_t hit;
    } vec_t;

    vec_t tbl[7];

    rd53_sync_fe_digital_ctrl #(
        .TOT_W      (4),
        .BCID_W     (8),
        .AZ_PERIOD  (AZ_P),
        .AZ_LEN     (AZ_L),
        .SETTLE_LEN (SET_L),
        .OVF_W      (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_disc_in   (disc_in),
        .i_bcid      (bcid),
        .i_az_force  (az_force),
        .o_phi_az_to (o_phi),
        .o_strobe_to (o_strobe),
        .o_hit_valid (o_valid),
        .i_hit_ready (hit_ready),
        .o_hit_tot   (o_tot),
        .o_hit_bcid  (o_bcid),
        .o_ovf_cnt   (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_ds = 0; m_dsp = 0;
        m_az_left = 0; m_set_left = 0; m_since = 0; m_tot = 0; m_hb = 0;
        m_live = 0; m_pulse = 0; m_pend = 0;
        m_vld = 0; m_otot = 0; m_obc = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit en, input bit d, input int bc, input bit f, input bit r);
        bit lead;
        bit emit;
        bit req;
        bit go_az;
        lead  = m_ds && !m_dsp;
        emit  = 0;
        go_az = 0;
        if (!en) begin
            m_az_left = 0; m_set_left = 0; m_live = 0; m_pulse = 0; m_pend = 0;
        end else if (m_az_left > 0) begin
            m_az_left--;
            if (m_az_left == 0) begin
                m_set_left = SET_L;
                m_since    = 0;
            end
        end else if (m_set_left > 0) begin
            m_set_left--;
            if (m_set_left == 0) m_live = 1;
        end else if (!m_live) begin
            m_az_left = AZ_L;
        end else begin
            req = m_pend || f || (m_since == AZ_P - 1);
            if (!m_pulse) begin
                if (lead) begin
                    m_pulse = 1; m_tot = 1; m_hb = bc & 255; m_pend = req;
                end else begin
                    go_az = req;
                end
            end else if (m_ds) begin
                m_tot  = (m_tot < TOT_MAX) ? m_tot + 1 : TOT_MAX;
                m_pend = req;
            end else begin
                emit    = 1;
                m_pulse = 0;
                go_az   = req;
            end
            if (m_since < AZ_P - 1) m_since++;
            if (go_az) begin
                m_live = 0; m_pend = 0; m_az_left = AZ_L;
            end
        end
        if (emit && (!m_vld || r)) begin
            m_vld = 1; m_otot = m_tot; m_obc = m_hb;
        end else if (emit) begin
            m_ovf = (m_ovf < OVF_MAX) ? m_ovf + 1 : OVF_MAX;
        end else if (m_vld && r) begin
            m_vld = 0;
        end
        m_dsp = m_ds;
        m_ds  = m_s1;
        m_s1  = d;
    endtask

    task automatic cyc(input bit en, input bit d, input bit f, input bit r);
        enable = en; disc_in = d; az_force = f; hit_ready = r; bcid = 8'(bc_ctr);
        model_step(en, d, bc_ctr, f, r);
        bc_ctr++;
        @(posedge clk);
        #1;
        chk("phi_az", o_phi, (m_az_left > 0));
        chk("strobe", o_strobe, m_live);
        chk("hit_valid", o_valid, m_vld);
        chk("hit_tot", o_tot, m_otot);
        chk("hit_bcid", o_bcid, m_obc);
        chk("ovf_cnt", o_ovf, m_ovf);
    endtask

    task automatic wait_armed();
        int n;
        n = 0;
        while (o_strobe !== 1'b1 && n < 100) begin
            cyc(1, 0, 0, 1);
            n++;
        end
        chk("wait_armed", (o_strobe === 1'b1), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_phi"}, o_phi, 0);
        chk({tag, "_strobe"}, o_strobe, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_tot"}, o_tot, 0);
        chk({tag, "_bcid"}, o_bcid, 0);
        chk({tag, "_ovf"}, o_ovf, 0);
    endtask

    initial begin
        int nval;
        int nphi;
        int run;
        bit dv;
        bit seen;

        tbl[0] = '{4, 1, 0, 1, 1, 0, 0, '{tot: 4'd0, bcid: 8'h00}};
        tbl[1] = '{2, 1, 0, 1, 0, 0, 0, '{tot: 4'd0, bcid: 8'h00}};
        tbl[2] = '{1, 1, 0, 1, 0, 1, 0, '{tot: 4'd0, bcid: 8'h00}};
        tbl[3] = '{5, 1, 1, 1, 0, 1, 0, '{tot: 4'd0, bcid: 8'h00}};
        tbl[4] = '{2, 1, 0, 1, 0, 1, 0, '{tot: 4'd0, bcid: 8'h00}};
        tbl[5] = '{1, 1, 0, 1, 0, 1, 1, '{tot: 4'd5, bcid: 8'h12}};
        tbl[6] = '{2, 1, 0, 1, 0, 1, 0, '{tot: 4'd5, bcid: 8'h12}};

        model_reset();
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Power-up autozero, settle, then a 5-clock pulse at BCID 0x12.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < tbl[i].rep; k++) begin
                bc_ctr = 'h12;
                cyc(tbl[i].en, tbl[i].disc, 0, tbl[i].rdy);
                chk($sformatf("tbl%0d_phi", i), o_phi, tbl[i].phi);
                chk($sformatf("tbl%0d_strobe", i), o_strobe, tbl[i].strb);
                chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].vld);
                chk($sformatf("tbl%0d_tot", i), o_tot, tbl[i].hit.tot);
                chk($sformatf("tbl%0d_bcid", i), o_bcid, tbl[i].hit.bcid);
                chk($sformatf("tbl%0d_ovf", i), o_ovf, 0);
            end
        end

        // Long pulse saturates ToT and spans timer expiry; autozero follows the emit.
        for (int i = 0; i < 40; i++) cyc(1, 1, 0, 1);
        nval = 0;
        nphi = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 1);
            if (o_phi) nphi++;
            if (o_valid) begin
                nval++;
                if (!seen) begin
                    chk("sat_tot", o_tot, 15);
                    chk("sat_phi_with_emit", o_phi, 1);
                    seen = 1;
                end
            end
        end
        chk("sat_records", nval, 1);
        chk("sat_az_len", nphi, 4);

        // Forced autozero from ARMED.
        wait_armed();
        cyc(1, 0, 1, 1);
        chk("force_az", o_phi, 1);

        // Backpressure: three 2-clock pulses with the output blocked.
        wait_armed();
        for (int p = 0; p < 3; p++) begin
            cyc(1, 1, 0, 0);
            cyc(1, 1, 0, 0);
            for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
        end
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("bp_valid", o_valid, 1);
        chk("bp_tot", o_tot, 2);
        chk("bp_ovf", o_ovf, 2);
        cyc(1, 0, 0, 1);
        chk("bp_drain", o_valid, 0);
        nval = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1);
            if (o_valid) nval++;
        end
        chk("bp_no_extra", nval, 0);

        // ENABLE dropped in the middle of a pulse discards it.
        wait_armed();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 1);
        chk("dis_phi", o_phi, 0);
        chk("dis_strobe", o_strobe, 0);
        chk("dis_valid", o_valid, 0);
        chk("dis_ovf", o_ovf, 2);
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1);
            if (o_valid) nval++;
        end
        cyc(1, 0, 0, 1);
        chk("reen_az", o_phi, 1);
        cyc(1, 0, 0, 1);
        if (o_valid) nval++;
        chk("dis_no_hit", nval, 0);

        // Asynchronous reset in the middle of an autozero.
        rst = 1'b1;
        #1 check_all_zero("rst_mid_az");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against the model.
        run = 0;
        dv  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                dv  = !dv;
                run = dv ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 12));
            end
            run--;
            cyc($urandom_range(0, 99) != 0, dv, $urandom_range(0, 149) == 0,
                $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
